// File: rtl/pd_pkg.sv
// Shared defaults and FSM encoding for the linked descriptor queue manager.
package pd_pkg;

    localparam int NUM_Q_DEF = 4;
    localparam int DEPTH_DEF = 512;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pd_state_e;

endpackage

// File: rtl/pd_free_fifo.sv
// Free-pointer FIFO: self-fills with 0..DEPTH-1, then serves allocations and
// accepts releases, forwarding a release straight to an allocation when empty.
module pd_free_fifo
    import pd_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fill,
    input  logic             alloc_req,
    input  logic             rel_vld,
    input  logic [PTR_W-1:0] rel_ptr,
    output logic             alloc_gnt,
    output logic [PTR_W-1:0] alloc_ptr,
    output logic             rel_drop,
    output logic [CNT_W-1:0] free_cnt
);

    logic [PTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_idx, wr_idx;
    logic [CNT_W-1:0] cnt;
    logic             empty, full, push, bypass, wr_en, rd_adv;
    logic [PTR_W-1:0] wr_data;

    always_comb begin
        empty     = (cnt == '0);
        full      = (cnt == CNT_W'(DEPTH));
        push      = rel_vld & ~full;
        rel_drop  = rel_vld & full;
        alloc_gnt = alloc_req & (~empty | push);
        // An empty FIFO hands the released pointer straight through; nothing is stored.
        bypass    = alloc_gnt & empty;
        wr_en     = fill | (push & ~bypass);
        wr_data   = fill ? wr_idx : rel_ptr;
        rd_adv    = alloc_gnt & ~bypass;
        alloc_ptr = empty ? rel_ptr : mem[rd_idx];
        free_cnt  = cnt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_idx <= '0;
            wr_idx <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en)  wr_idx <= wr_idx + PTR_W'(1);
            if (rd_adv) rd_idx <= rd_idx + PTR_W'(1);
            if (fill)   cnt <= cnt + CNT_W'(1);
            else        cnt <= cnt + CNT_W'(push) - CNT_W'(alloc_gnt);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

endmodule

// File: rtl/pd_linked_queue_mgr.sv
// Linked-list descriptor queue manager: NUM_Q queues threaded through a shared
// next-pointer array, fed from a self-initialising free list.
module pd_linked_queue_mgr
    import pd_pkg::*;
#(
    parameter int  NUM_Q = NUM_Q_DEF,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int QID_W = $clog2(NUM_Q),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    output logic                   init_done,
    input  logic                   alloc_req,
    output logic                   alloc_gnt,
    output logic [PTR_W-1:0]       alloc_ptr,
    input  logic                   rel_vld,
    input  logic [PTR_W-1:0]       rel_ptr,
    input  logic                   enq_vld,
    input  logic [QID_W-1:0]       enq_qid,
    input  logic [PTR_W-1:0]       enq_ptr,
    input  logic                   enq_eop,
    input  logic                   deq_req,
    input  logic [QID_W-1:0]       deq_qid,
    output logic                   deq_gnt,
    output logic [PTR_W-1:0]       deq_ptr,
    output logic                   deq_eop,
    output logic [NUM_Q-1:0]       q_rdy,
    output logic [NUM_Q*CNT_W-1:0] q_cnt,
    output logic [NUM_Q*CNT_W-1:0] q_frm,
    output logic [CNT_W-1:0]       free_cnt,
    output logic                   err
);

    pd_state_e        state_q, state_d;
    logic             run, rel_drop, enq_ok, enq_drop, deq_err;
    logic [PTR_W-1:0] head_q [NUM_Q];
    logic [PTR_W-1:0] tail_q [NUM_Q];
    logic [CNT_W-1:0] cnt_q  [NUM_Q];
    logic [CNT_W-1:0] frm_q  [NUM_Q];
    logic [NUM_Q-1:0] head_eop_q, enq_hit, deq_hit;
    logic [PTR_W:0]   next_mem [DEPTH];
    logic [PTR_W:0]   deq_nxt;

    assign run       = (state_q == ST_RUN);
    assign init_done = run;

    pd_free_fifo #(.DEPTH(DEPTH)) u_free_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .fill      (~run),
        .alloc_req (alloc_req & run),
        .rel_vld   (rel_vld & run),
        .rel_ptr   (rel_ptr),
        .alloc_gnt (alloc_gnt),
        .alloc_ptr (alloc_ptr),
        .rel_drop  (rel_drop),
        .free_cnt  (free_cnt)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && free_cnt == CNT_W'(DEPTH - 1)) state_d = ST_RUN;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            q_rdy[i]                = (cnt_q[i] != '0);
            q_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
            q_frm[i*CNT_W +: CNT_W] = frm_q[i];
        end
        enq_ok   = run & enq_vld & (free_cnt != '0);
        enq_drop = run & enq_vld & (free_cnt == '0);
        deq_gnt  = run & deq_req & q_rdy[deq_qid];
        deq_err  = run & deq_req & ~q_rdy[deq_qid];
        deq_ptr  = head_q[deq_qid];
        deq_eop  = head_eop_q[deq_qid];
        deq_nxt  = next_mem[head_q[deq_qid]];
        enq_hit  = '0;
        deq_hit  = '0;
        if (enq_ok)  enq_hit[enq_qid] = 1'b1;
        if (deq_gnt) deq_hit[deq_qid] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_Q; i++) begin
                head_q[i]     <= '0;
                tail_q[i]     <= '0;
                cnt_q[i]      <= '0;
                frm_q[i]      <= '0;
                head_eop_q[i] <= 1'b0;
            end
            err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                if (deq_hit[i]) begin
                    head_q[i]     <= deq_nxt[PTR_W-1:0];
                    head_eop_q[i] <= deq_nxt[PTR_W];
                end
                // The enqueued pointer becomes head when the queue is, or is just becoming, empty.
                if (enq_hit[i]) begin
                    tail_q[i] <= enq_ptr;
                    if (cnt_q[i] == '0 || (deq_hit[i] && cnt_q[i] == CNT_W'(1))) begin
                        head_q[i]     <= enq_ptr;
                        head_eop_q[i] <= enq_eop;
                    end
                end
                cnt_q[i] <= cnt_q[i] + CNT_W'(enq_hit[i]) - CNT_W'(deq_hit[i]);
                frm_q[i] <= frm_q[i] + CNT_W'(enq_hit[i] & enq_eop)
                                     - CNT_W'(deq_hit[i] & head_eop_q[i]);
            end
            err <= err | rel_drop | enq_drop | deq_err;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_ok && cnt_q[enq_qid] != '0) next_mem[tail_q[enq_qid]] <= {enq_eop, enq_ptr};
    end

endmodule

// File: tb/tb_pd_linked_queue_mgr.sv
// Directed bench for pd_linked_queue_mgr: init fill, allocation, queue traffic,
// error cases, free-list bypass and mid-traffic reset.
module tb_pd_linked_queue_mgr;

    localparam int NUM_Q = 4;
    localparam int DEPTH = 512;
    localparam int PTR_W = 9;
    localparam int QID_W = 2;
    localparam int CNT_W = 10;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   init_done;
    logic                   alloc_req, alloc_gnt;
    logic [PTR_W-1:0]       alloc_ptr;
    logic                   rel_vld;
    logic [PTR_W-1:0]       rel_ptr;
    logic                   enq_vld, enq_eop;
    logic [QID_W-1:0]       enq_qid;
    logic [PTR_W-1:0]       enq_ptr;
    logic                   deq_req, deq_gnt, deq_eop;
    logic [QID_W-1:0]       deq_qid;
    logic [PTR_W-1:0]       deq_ptr;
    logic [NUM_Q-1:0]       q_rdy;
    logic [NUM_Q*CNT_W-1:0] q_cnt, q_frm;
    logic [CNT_W-1:0]       free_cnt;
    logic                   err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pd_linked_queue_mgr #(.NUM_Q(NUM_Q), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .init_done(init_done),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_ptr(alloc_ptr),
        .rel_vld(rel_vld), .rel_ptr(rel_ptr),
        .enq_vld(enq_vld), .enq_qid(enq_qid), .enq_ptr(enq_ptr), .enq_eop(enq_eop),
        .deq_req(deq_req), .deq_qid(deq_qid), .deq_gnt(deq_gnt), .deq_ptr(deq_ptr),
        .deq_eop(deq_eop), .q_rdy(q_rdy), .q_cnt(q_cnt), .q_frm(q_frm),
        .free_cnt(free_cnt), .err(err)
    );

    typedef struct {
        logic             enq_vld;
        logic [QID_W-1:0] enq_qid;
        logic [PTR_W-1:0] enq_ptr;
        logic             enq_eop;
        logic             deq_req;
        logic [QID_W-1:0] deq_qid;
        logic             exp_gnt;
        int               exp_ptr;
        int               exp_eop;
        int               chk_q;
        int               exp_cnt;
        int               exp_frm;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input int ev, input int eq, input int ep, input int ee,
                                input int dr, input int dq, input int g, input int gp,
                                input int ge, input int cq, input int c, input int f);
        vec_t v;
        v.enq_vld = ev[0];  v.enq_qid = QID_W'(eq); v.enq_ptr = PTR_W'(ep); v.enq_eop = ee[0];
        v.deq_req = dr[0];  v.deq_qid = QID_W'(dq); v.exp_gnt = g[0];
        v.exp_ptr = gp;     v.exp_eop = ge;          v.chk_q = cq;
        v.exp_cnt = c;      v.exp_frm = f;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int qc(input int q);
        return int'(q_cnt[q*CNT_W +: CNT_W]);
    endfunction

    function automatic int qf(input int q);
        return int'(q_frm[q*CNT_W +: CNT_W]);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req = 1'b0; rel_vld = 1'b0; rel_ptr = '0;
        enq_vld = 1'b0; enq_qid = '0; enq_ptr = '0; enq_eop = 1'b0;
        deq_req = 1'b0; deq_qid = '0;
    endtask

    task automatic wait_init(input int start);
        int cyc = start;
        while (!init_done && cyc < 600) begin
            cycle();
            cyc++;
        end
        chk("init_cycles", cyc, DEPTH);
        chk("init_free_cnt", int'(free_cnt), DEPTH);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (2) cycle();
        rstn = 1'b1;
    endtask

    task automatic apply_vec(input int k);
        vec_t v = vecs[k];
        enq_vld = v.enq_vld; enq_qid = v.enq_qid; enq_ptr = v.enq_ptr; enq_eop = v.enq_eop;
        deq_req = v.deq_req; deq_qid = v.deq_qid;
        #4;
        chk($sformatf("v%0d_deq_gnt", k), int'(deq_gnt), int'(v.exp_gnt));
        if (v.exp_gnt) begin
            chk($sformatf("v%0d_deq_ptr", k), int'(deq_ptr), v.exp_ptr);
            chk($sformatf("v%0d_deq_eop", k), int'(deq_eop), v.exp_eop);
        end
        cycle();
        idle_inputs();
        chk($sformatf("v%0d_q_cnt", k), qc(v.chk_q), v.exp_cnt);
        chk($sformatf("v%0d_q_frm", k), qf(v.chk_q), v.exp_frm);
        chk($sformatf("v%0d_q_rdy", k), int'(q_rdy[v.chk_q]), int'(v.exp_cnt != 0));
    endtask

    initial begin
        //            ev eq  ep ee dr dq  g  gp ge cq  c  f
        vecs[0]  = mk(1, 2,  5, 0, 0, 0, 0,  0, 0, 2, 1, 0);
        vecs[1]  = mk(1, 2,  9, 1, 0, 0, 0,  0, 0, 2, 2, 1);
        vecs[2]  = mk(1, 2,  3, 0, 0, 0, 0,  0, 0, 2, 3, 1);
        vecs[3]  = mk(0, 0,  0, 0, 1, 2, 1,  5, 0, 2, 2, 1);
        vecs[4]  = mk(0, 0,  0, 0, 1, 2, 1,  9, 1, 2, 1, 0);
        vecs[5]  = mk(0, 0,  0, 0, 1, 2, 1,  3, 0, 2, 0, 0);
        vecs[6]  = mk(1, 1,  7, 1, 0, 0, 0,  0, 0, 1, 1, 1);
        vecs[7]  = mk(1, 1,  8, 0, 1, 1, 1,  7, 1, 1, 1, 0);
        vecs[8]  = mk(0, 0,  0, 0, 1, 1, 1,  8, 0, 1, 0, 0);
        vecs[9]  = mk(1, 1, 20, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        vecs[10] = mk(1, 0, 21, 1, 1, 1, 1, 20, 0, 0, 1, 1);
        vecs[11] = mk(0, 0,  0, 0, 1, 0, 1, 21, 1, 0, 0, 0);

        // Reset state, with requests held to show they are ignored.
        rstn = 1'b0;
        idle_inputs();
        alloc_req = 1'b1;
        repeat (2) cycle();
        #4;
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_alloc_gnt", int'(alloc_gnt), 0);
        chk("rst_free_cnt", int'(free_cnt), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_q_cnt_zero", int'(q_cnt != '0), 0);
        cycle();
        rstn = 1'b1;

        // Requests during INIT must have no effect.
        alloc_req = 1'b1; rel_vld = 1'b1; rel_ptr = 9'd77;
        enq_vld = 1'b1; enq_qid = 2'd1; enq_ptr = 9'd4;
        deq_req = 1'b1; deq_qid = 2'd0;
        #4;
        chk("init_alloc_gnt", int'(alloc_gnt), 0);
        chk("init_deq_gnt", int'(deq_gnt), 0);
        repeat (5) cycle();
        idle_inputs();
        chk("init_err", int'(err), 0);
        chk("init_free_cnt5", int'(free_cnt), 5);
        chk("init_q_cnt1", qc(1), 0);
        wait_init(5);

        // Release into a full free list.
        chk("full_alloc_ptr_pre", int'(alloc_ptr), 0);
        rel_vld = 1'b1; rel_ptr = 9'd100;
        cycle();
        idle_inputs();
        chk("full_rel_err", int'(err), 1);
        chk("full_rel_free_cnt", int'(free_cnt), DEPTH);
        chk("full_rel_alloc_ptr", int'(alloc_ptr), 0);

        do_reset();
        chk("rst2_err", int'(err), 0);
        wait_init(0);

        // First allocations come out in fill order.
        alloc_req = 1'b1;
        #4;
        chk("alloc0_gnt", int'(alloc_gnt), 1);
        chk("alloc0_ptr", int'(alloc_ptr), 0);
        cycle();
        #4;
        chk("alloc1_ptr", int'(alloc_ptr), 1);
        cycle();
        alloc_req = 1'b0;
        chk("alloc_free_cnt", int'(free_cnt), DEPTH - 2);

        for (int k = 0; k < 12; k++) apply_vec(k);
        chk("queue_err", int'(err), 0);

        // Dequeue from an empty queue.
        deq_req = 1'b1; deq_qid = 2'd0;
        #4;
        chk("deq_empty_gnt", int'(deq_gnt), 0);
        cycle();
        idle_inputs();
        chk("deq_empty_err", int'(err), 1);
        chk("deq_empty_q_cnt", qc(0), 0);
        chk("deq_empty_free_cnt", int'(free_cnt), DEPTH - 2);

        // Drain the free list, then exercise the release-to-alloc bypass.
        alloc_req = 1'b1;
        for (int k = 0; k < 600 && free_cnt != '0; k++) cycle();
        chk("drain_free_cnt", int'(free_cnt), 0);
        #4;
        chk("empty_alloc_gnt", int'(alloc_gnt), 0);
        cycle();
        rel_vld = 1'b1; rel_ptr = 9'd42;
        #4;
        chk("bypass_gnt", int'(alloc_gnt), 1);
        chk("bypass_ptr", int'(alloc_ptr), 42);
        cycle();
        idle_inputs();
        chk("bypass_free_cnt", int'(free_cnt), 0);

        // Refill a little, load q3 with 10 descriptors, then reset mid-traffic.
        for (int k = 0; k < 10; k++) begin
            rel_vld = 1'b1; rel_ptr = PTR_W'(100 + k);
            cycle();
        end
        idle_inputs();
        chk("refill_free_cnt", int'(free_cnt), 10);
        for (int k = 0; k < 10; k++) begin
            enq_vld = 1'b1; enq_qid = 2'd3; enq_ptr = PTR_W'(100 + k); enq_eop = 1'b0;
            cycle();
        end
        chk("q3_cnt", qc(3), 10);
        enq_ptr = 9'd200; alloc_req = 1'b1; deq_req = 1'b1; deq_qid = 2'd3;
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_q_cnt_zero", int'(q_cnt != '0), 0);
        chk("midrst_q_rdy", int'(q_rdy), 0);
        chk("midrst_init_done", int'(init_done), 0);
        chk("midrst_free_cnt", int'(free_cnt), 0);
        chk("midrst_err", int'(err), 0);
        idle_inputs();
        cycle();
        cycle();
        rstn = 1'b1;
        wait_init(0);
        chk("reinit_q3_cnt", qc(3), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
